// File: rtl/line_window_buffer_pkg.sv
// Shared LeNet constants and elaboration-time helpers for the streaming
// window generators.
package line_window_buffer_pkg;

  localparam int unsigned DEFAULT_BIT_WIDTH = 8;
  localparam int unsigned IMG_COLS          = 28;
  localparam int unsigned IMG_ROWS          = 28;
  localparam int unsigned C1_KSIZE          = 5;
  localparam int unsigned C3_CH             = 6;

  // Index width for a count of v; never below one bit so ports stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) n = i + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/line_window_buffer_line_shift_row.sv
// One image row of delay: an enable-gated shift register whose tail is the
// pixel accepted COLS enables earlier.
module line_shift_row
  import line_window_buffer_pkg::*;
#(
  parameter int unsigned COLS      = IMG_COLS,
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] din,
  output logic [BIT_WIDTH-1:0] dout
);

  logic [BIT_WIDTH-1:0] mem [COLS];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < COLS; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[COLS-1];

endmodule

// File: rtl/line_window_buffer.sv
// Streaming KSIZE x KSIZE sliding-window generator with per-channel line
// buffers, frame position tracking, start-of-frame resync and backpressure.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int unsigned COLS      = IMG_COLS,
  parameter int unsigned ROWS      = IMG_ROWS,
  parameter int unsigned KSIZE     = C1_KSIZE,
  parameter int unsigned CH        = 1,
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_sof,
  input  logic [CH*BIT_WIDTH-1:0]               in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CH*KSIZE*KSIZE*BIT_WIDTH-1:0]   win_data,
  output logic [clog2(ROWS)-1:0]                win_row,
  output logic [clog2(COLS)-1:0]                win_col,
  output logic                                  win_last,
  output logic                                  frame_done
);

  localparam int unsigned RW = clog2(ROWS);
  localparam int unsigned CW = clog2(COLS);

  logic          accept;
  logic          take;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] pix_row;
  logic [CW-1:0] pix_col;
  logic          pos_valid;
  logic          pos_last;

  logic [BIT_WIDTH-1:0] lb_out [CH][KSIZE-1];
  logic [BIT_WIDTH-1:0] win_q  [CH][KSIZE][KSIZE];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // A cleared cycle drops the pixel, so nothing downstream of accept may move.
  assign take     = accept && !clear;

  assign pix_row   = in_sof ? '0 : row_cnt;
  assign pix_col   = in_sof ? '0 : col_cnt;
  assign pos_valid = (pix_row >= RW'(KSIZE-1)) && (pix_col >= CW'(KSIZE-1));
  assign pos_last  = (pix_row == RW'(ROWS-1)) && (pix_col == CW'(COLS-1));

  for (genvar ch = 0; ch < CH; ch++) begin : g_ch
    for (genvar j = 0; j < KSIZE-1; j++) begin : g_row
      logic [BIT_WIDTH-1:0] din;
      if (j == 0) begin : g_head
        assign din = in_data[ch*BIT_WIDTH +: BIT_WIDTH];
      end else begin : g_chain
        assign din = lb_out[ch][j-1];
      end
      line_shift_row #(
        .COLS      (COLS),
        .BIT_WIDTH (BIT_WIDTH)
      ) u_row (
        .clk  (clk),
        .en   (take),
        .din  (din),
        .dout (lb_out[ch][j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CH; c++)
        for (int unsigned r = 0; r < KSIZE; r++)
          for (int unsigned k = 0; k < KSIZE; k++)
            win_q[c][r][k] <= '0;
    end else if (take) begin
      for (int unsigned c = 0; c < CH; c++) begin
        for (int unsigned r = 0; r < KSIZE; r++)
          for (int unsigned k = 0; k < KSIZE-1; k++)
            win_q[c][r][k] <= win_q[c][r][k+1];
        win_q[c][KSIZE-1][KSIZE-1] <= in_data[c*BIT_WIDTH +: BIT_WIDTH];
        for (int unsigned j = 0; j < KSIZE-1; j++)
          win_q[c][KSIZE-2-j][KSIZE-1] <= lb_out[c][j];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned c = 0; c < CH; c++)
      for (int unsigned r = 0; r < KSIZE; r++)
        for (int unsigned k = 0; k < KSIZE; k++)
          win_data[((c*KSIZE+r)*KSIZE+k)*BIT_WIDTH +: BIT_WIDTH] = win_q[c][r][k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      out_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      out_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        out_valid  <= pos_valid;
        win_row    <= pix_row - RW'(KSIZE-1);
        win_col    <= pix_col - CW'(KSIZE-1);
        win_last   <= pos_last;
        frame_done <= pos_last;
        if (pix_col == CW'(COLS-1)) begin
          col_cnt <= '0;
          row_cnt <= pos_last ? '0 : pix_row + RW'(1);
        end else begin
          col_cnt <= pix_col + CW'(1);
          row_cnt <= pix_row;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Streaming sliding-window generator for the LeNet-5 convolution layers.
- Accepts one multi-channel pixel per handshake in raster order.
- Stores KSIZE-1 previous rows per channel in enabled shift-register line buffers.
- Emits a full KSIZE x KSIZE window per channel for every valid (unpadded, stride-1) convolution position.
- Sits between the image/feature-map source and the conv MAC array; generalises the single-channel fixed-row shift buffer with channels, kernel size, frame counting, start-of-frame resync and valid/ready backpressure.

Parameters:
- COLS, 28, pixels per row.
- ROWS, 28, rows per frame.
- KSIZE, 5, window height and width; legal range is 2..min(ROWS,COLS).
- CH, 1, channels processed in lockstep.
- BIT_WIDTH, 8, bits per pixel per channel.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: counters to 0, out_valid to 0; buffer contents are don't-care.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_sof  in  1  qualifies with the accepted pixel; that pixel is treated as (row 0, col 0).
- in_data  in  CH*BIT_WIDTH  channel c at bits [c*BIT_WIDTH +: BIT_WIDTH].
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- win_data  out  CH*KSIZE*KSIZE*BIT_WIDTH  element (c,r,k) at offset ((c*KSIZE+r)*KSIZE+k)*BIT_WIDTH; r=0 is the top (oldest) row, k=0 is the leftmost column.
- win_row  out  clog2(ROWS)  output row index of the window, 0..ROWS-KSIZE.
- win_col  out  clog2(COLS)  output column index of the window, 0..COLS-KSIZE.
- win_last  out  1  marks the last window of the frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset values: out_valid=0, win_last=0, frame_done=0, win_row=0, win_col=0, win_data=0, row_cnt=0, col_cnt=0. in_ready=1 out of reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output stage, no bubbles at full throughput).
  - accept = in_valid && in_ready.
  - Nothing shifts or counts without accept.
- Position of the accepted pixel: (r,c) = in_sof ? (0,0) : (row_cnt,col_cnt).
- Line buffers:
  - CH x (KSIZE-1) shift rows, each COLS deep, shifting only on accept.
  - Chain per channel: in_data -> lb[0] -> lb[1] -> ... -> lb[KSIZE-2].
  - lb[j] output equals the pixel j+1 rows above the current column.
- Window register, per channel, on accept:
  - Every row shifts left by one (k <- k+1).
  - New column k=KSIZE-1 gets: row KSIZE-1 = in_data; row KSIZE-2-j = lb[j] output.
- Output update on the cycle after accept:
  - out_valid = (r >= KSIZE-1 && c >= KSIZE-1).
  - win_row = r-(KSIZE-1), win_col = c-(KSIZE-1).
  - win_last = (r==ROWS-1 && c==COLS-1).
  - win_data reflects the updated window register.
- Latency: 1 cycle from accepting pixel (r,c) to its window.
- When out_valid is high and out_ready is low, all outputs hold stable and in_ready=0.
- If there is no accept and out_ready=1, out_valid clears.
- Counters:
  - col_cnt wraps COLS-1 -> 0 and increments row_cnt.
  - At (ROWS-1, COLS-1), both counters go to 0 and frame_done pulses for one cycle (registered, aligned with win_last).
- Windows spanning a row wrap contain stale data; the validity gating above suppresses them. No windows are emitted for rows 0..KSIZE-2 of a new frame.
- in_sof mid-frame: the partial frame is abandoned, with no frame_done for it; the stale buffer contents are masked by the row gating.
- clear and accept in the same cycle: clear wins and the pixel is dropped.
- rst_n low mid-frame takes effect immediately; the line buffers need no reset.
- Windows per frame: (ROWS-KSIZE+1)*(COLS-KSIZE+1).

Decomposition:
- Shared lenet header/package: BIT_WIDTH default, LeNet constants (IMG_COLS=28, IMG_ROWS=28, C1_KSIZE=5, C3_CH=6), and a clog2 function.
- Sub-module line_shift_row (COLS, BIT_WIDTH, en-gated shift register with tail output), instantiated CH*(KSIZE-1) times.
- Counters, window registers and the output stage live in the top module.

Test Plan:
- Parameters COLS=6, ROWS=6, KSIZE=3, CH=1, pixel=r*6+c; continuous valid, out_ready=1:
  - The first out_valid comes 1 cycle after accepting (2,2), with win_data rows {0,1,2},{6,7,8},{12,13,14} and win_row=0, win_col=0.
  - 16 windows per frame.
  - The last window is {21,22,23},{27,28,29},{33,34,35} with win_last=1 and frame_done=1.
- Same stream with out_ready low for 5 cycles at window (1,1):
  - Outputs hold {7,8,9},{13,14,15},{19,20,21}; in_ready=0.
  - No pixel is lost; the full set of 16 windows is still produced, in order.
- Two back-to-back frames, the second with in_sof on pixel 0: no window is emitted before the second frame's (2,2). Second-frame windows match the first-frame windows plus an offset of 100 in data values.
- in_sof asserted at the first frame's (3,4): frame_done is not pulsed, and the next window is (0,0) of the new frame, built only from new data.
- CH=2 with channel1 = 255-pixel: the channel1 window at (0,0) is {255,254,253},{249,248,247},{243,242,241}.
- rst_n pulsed low at (4,1), then a new frame: all outputs are 0 during reset, and the subsequent frame produces 16 correct windows.
